// File: rtl/hours_pkg.sv
// hours_pkg: shared types, limits and helpers for the hour counter.
//   hr_state_t  : RUN / SET operating state
//   hr_val_t    : packed hour value {tens, units, pm}
//   HR*_MAX_*   : last legal hour before rollover, per counting mode
//   hr_rst_val  : reset hour for a mode (00 or 12 AM)
//   hr_legal    : true when a value is a reachable hour for a mode
package hours_pkg;

  typedef enum logic {RUN = 1'b0, SET = 1'b1} hr_state_t;

  typedef struct packed {
    logic [1:0] l;   // tens digit
    logic [3:0] r;   // units digit
    logic       pm;  // PM flag (12h only)
  } hr_val_t;

  localparam logic [1:0] HR24_MAX_L = 2'd2;
  localparam logic [3:0] HR24_MAX_R = 4'd3;
  localparam logic [1:0] HR12_MAX_L = 2'd1;
  localparam logic [3:0] HR12_MAX_R = 4'd2;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  function automatic hr_val_t hr_rst_val(input logic mode24);
    hr_val_t v;
    v.pm = 1'b0;
    if (mode24) begin
      v.l = 2'd0;
      v.r = 4'd0;
    end else begin
      v.l = HR12_MAX_L;
      v.r = HR12_MAX_R;
    end
    return v;
  endfunction

  function automatic logic hr_legal(input hr_val_t v, input logic mode24);
    logic ok;
    if (mode24)
      ok = !v.pm && (v.r <= BCD_MAX) &&
           ((v.l < HR24_MAX_L) || (v.l == HR24_MAX_L && v.r <= HR24_MAX_R));
    else
      ok = (v.r <= BCD_MAX) &&
           ((v.l == 2'd0 && v.r != 4'd0) ||
            (v.l == HR12_MAX_L && v.r <= HR12_MAX_R));
    return ok;
  endfunction

endpackage

// File: rtl/hours_counter_if.sv
// hours_counter_if: control inputs and display outputs of the hour counter.
//   hr_tick            : one-cycle carry from the minutes counter
//   set/inc/dec_btn    : raw asynchronous push-buttons
//   leftHr / rightHr   : BCD tens / units digits
//   pm                 : PM flag (12h mode)
//   setting            : high while in SET
//   day_tick           : one-cycle midnight pulse
// master = driver of the counter (minutes counter / buttons), slave = counter.
interface hours_counter_if;
  logic       hr_tick;
  logic       set_btn;
  logic       inc_btn;
  logic       dec_btn;
  logic [1:0] leftHr;
  logic [3:0] rightHr;
  logic       pm;
  logic       setting;
  logic       day_tick;

  modport master (
    output hr_tick, set_btn, inc_btn, dec_btn,
    input  leftHr, rightHr, pm, setting, day_tick
  );

  modport slave (
    input  hr_tick, set_btn, inc_btn, dec_btn,
    output leftHr, rightHr, pm, setting, day_tick
  );
endinterface

// File: rtl/hours_counter_btn_sync_edge.sv
// btn_sync_edge: two-flop synchroniser followed by a registered rising-edge
// detector. Produces exactly one clk-wide pulse per press, however long held.
//   clk, rst : system clock, async active-high reset
//   btn_i    : raw asynchronous button
//   pulse_o  : one-cycle pulse, three edges after the raw rise
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);
  logic sync1_q, sync2_q, prev_q, pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/hours_counter.sv
// hours_counter: BCD hour counter with RUN/SET FSM and button adjustment.
//   MODE_24 : 1 = 00..23, 0 = 12,1..11 with pm flag
//   clk     : system clock
//   rst     : async active-high reset
//   bus     : hours_counter_if.slave (hr_tick, buttons in; digits, pm,
//             setting, day_tick out)
module hours_counter
  import hours_pkg::*;
#(
  parameter bit MODE_24 = 1'b1
) (
  input logic             clk,
  input logic             rst,
  hours_counter_if.slave  bus
);
  localparam int NUM_BTN = 3;
  localparam int B_SET = 0, B_INC = 1, B_DEC = 2;

  logic [NUM_BTN-1:0] btn_raw, btn_p;

  assign btn_raw[B_SET] = bus.set_btn;
  assign btn_raw[B_INC] = bus.inc_btn;
  assign btn_raw[B_DEC] = bus.dec_btn;

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_sync_edge u_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_raw[g]),
        .pulse_o (btn_p[g])
      );
    end
  endgenerate

  hr_state_t state_q, state_d;
  hr_val_t   hr_q, hr_d;
  logic      day_q, day_d;

  hr_val_t   inc_v, dec_v;
  logic      inc_wrap;

  // Increment path; inc_wrap marks a rollover into midnight.
  always_comb begin
    inc_v    = hr_q;
    inc_wrap = 1'b0;
    if (MODE_24) begin
      if (hr_q.l == HR24_MAX_L && hr_q.r == HR24_MAX_R) begin
        inc_v.l  = 2'd0;
        inc_v.r  = 4'd0;
        inc_wrap = 1'b1;
      end else if (hr_q.r == BCD_MAX) begin
        inc_v.l = hr_q.l + 2'd1;
        inc_v.r = 4'd0;
      end else begin
        inc_v.r = hr_q.r + 4'd1;
      end
    end else begin
      if (hr_q.l == HR12_MAX_L && hr_q.r == HR12_MAX_R) begin
        inc_v.l = 2'd0;
        inc_v.r = 4'd1;
      end else if (hr_q.l == 2'd1 && hr_q.r == 4'd1) begin
        // 11 -> 12 flips AM/PM; only 11 PM -> 12 AM is midnight
        inc_v.r  = HR12_MAX_R;
        inc_v.pm = ~hr_q.pm;
        inc_wrap = hr_q.pm;
      end else if (hr_q.r == BCD_MAX) begin
        inc_v.l = 2'd1;
        inc_v.r = 4'd0;
      end else begin
        inc_v.r = hr_q.r + 4'd1;
      end
    end
  end

  // Decrement path.
  always_comb begin
    dec_v = hr_q;
    if (MODE_24) begin
      if (hr_q.l == 2'd0 && hr_q.r == 4'd0) begin
        dec_v.l = HR24_MAX_L;
        dec_v.r = HR24_MAX_R;
      end else if (hr_q.r == 4'd0) begin
        dec_v.l = hr_q.l - 2'd1;
        dec_v.r = BCD_MAX;
      end else begin
        dec_v.r = hr_q.r - 4'd1;
      end
    end else begin
      if (hr_q.l == 2'd0 && hr_q.r == 4'd1) begin
        dec_v.l = HR12_MAX_L;
        dec_v.r = HR12_MAX_R;
      end else if (hr_q.l == HR12_MAX_L && hr_q.r == HR12_MAX_R) begin
        dec_v.r  = 4'd1;
        dec_v.pm = ~hr_q.pm;
      end else if (hr_q.r == 4'd0) begin
        dec_v.l = 2'd0;
        dec_v.r = BCD_MAX;
      end else begin
        dec_v.r = hr_q.r - 4'd1;
      end
    end
  end

  // FSM next-state and hour update.
  always_comb begin
    state_d = state_q;
    hr_d    = hr_q;
    day_d   = 1'b0;

    if (btn_p[B_SET])
      state_d = (state_q == RUN) ? SET : RUN;

    if (!hr_legal(hr_q, MODE_24)) begin
      hr_d = hr_rst_val(MODE_24);
    end else begin
      case (state_q)
        RUN: begin
          if (bus.hr_tick) begin
            hr_d  = inc_v;
            day_d = inc_wrap;
          end
        end
        SET: begin
          // hr_tick is dropped here; simultaneous inc+dec cancel
          if (btn_p[B_INC] && !btn_p[B_DEC])
            hr_d = inc_v;
          else if (btn_p[B_DEC] && !btn_p[B_INC])
            hr_d = dec_v;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      hr_q    <= hr_rst_val(MODE_24);
      day_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hr_q    <= hr_d;
      day_q   <= day_d;
    end
  end

  assign bus.leftHr   = hr_q.l;
  assign bus.rightHr  = hr_q.r;
  assign bus.pm       = MODE_24 ? 1'b0 : hr_q.pm;
  assign bus.setting  = (state_q == SET);
  assign bus.day_tick = day_q;
endmodule

// File: tb/tb_hours_counter.sv
module tb_hours_counter;
  logic clk = 1'b0;
  logic rst;
  logic hr_tick, set_btn, inc_btn, dec_btn;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hours_counter_if if24 ();
  hours_counter_if if12 ();

  assign if24.hr_tick = hr_tick;
  assign if24.set_btn = set_btn;
  assign if24.inc_btn = inc_btn;
  assign if24.dec_btn = dec_btn;
  assign if12.hr_tick = hr_tick;
  assign if12.set_btn = set_btn;
  assign if12.inc_btn = inc_btn;
  assign if12.dec_btn = dec_btn;

  hours_counter #(.MODE_24(1'b1)) dut24 (.clk(clk), .rst(rst), .bus(if24));
  hours_counter #(.MODE_24(1'b0)) dut12 (.clk(clk), .rst(rst), .bus(if12));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) hr_tick = 1'b1;
    @(negedge clk) hr_tick = 1'b0;
  endtask

  // which: 0 = set, 1 = inc, 2 = dec
  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: set_btn = 1'b1;
      1: inc_btn = 1'b1;
      default: dec_btn = 1'b1;
    endcase
    cyc(5);
    set_btn = 1'b0;
    inc_btn = 1'b0;
    dec_btn = 1'b0;
    cyc(2);
  endtask

  initial begin
    int h24, h12, pm_e;
    rst = 1'b1; hr_tick = 1'b0; set_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    #12;
    chk("rst24_l", if24.leftHr, 0);
    chk("rst24_r", if24.rightHr, 0);
    chk("rst24_set", if24.setting, 0);
    chk("rst24_day", if24.day_tick, 0);
    chk("rst12_l", if12.leftHr, 1);
    chk("rst12_r", if12.rightHr, 2);
    chk("rst12_pm", if12.pm, 0);
    @(negedge clk) rst = 1'b0;

    // 24 ticks through a full day in both modes
    for (int i = 1; i <= 24; i++) begin
      tick();
      h24  = i % 24;
      h12  = (i % 12 == 0) ? 12 : i % 12;
      pm_e = (i >= 12 && i < 24) ? 1 : 0;
      chk("run24_l", if24.leftHr, h24 / 10);
      chk("run24_r", if24.rightHr, h24 % 10);
      chk("run24_day", if24.day_tick, (i == 24) ? 1 : 0);
      chk("run12_l", if12.leftHr, h12 / 10);
      chk("run12_r", if12.rightHr, h12 % 10);
      chk("run12_pm", if12.pm, pm_e);
      chk("run12_day", if12.day_tick, (i == 24) ? 1 : 0);
    end
    cyc(1);
    chk("day24_one_cycle", if24.day_tick, 0);
    chk("day12_one_cycle", if12.day_tick, 0);

    // SET: dec from 00 wraps to 23, hr_tick ignored
    press(0);
    chk("set_enter", if24.setting, 1);
    press(2);
    chk("dec_wrap_l", if24.leftHr, 2);
    chk("dec_wrap_r", if24.rightHr, 3);
    tick(); tick(); tick();
    chk("set_tick_ign_l", if24.leftHr, 2);
    chk("set_tick_ign_r", if24.rightHr, 3);
    chk("set_tick_no_day", if24.day_tick, 0);
    press(0);
    chk("set_exit", if24.setting, 0);
    tick();
    chk("mid_l", if24.leftHr, 0);
    chk("mid_r", if24.rightHr, 0);
    chk("mid_day", if24.day_tick, 1);

    // held inc gives one step; simultaneous inc+dec cancels
    press(0);
    chk("set_enter2", if24.setting, 1);
    @(negedge clk) inc_btn = 1'b1;
    cyc(50);
    inc_btn = 1'b0;
    cyc(3);
    chk("hold_inc_l", if24.leftHr, 0);
    chk("hold_inc_r", if24.rightHr, 1);
    @(negedge clk) begin inc_btn = 1'b1; dec_btn = 1'b1; end
    cyc(5);
    inc_btn = 1'b0; dec_btn = 1'b0;
    cyc(3);
    chk("incdec_l", if24.leftHr, 0);
    chk("incdec_r", if24.rightHr, 1);
    press(0);
    chk("set_exit2", if24.setting, 0);

    // RUN at 09: hr_tick coincident with synchronised set edge
    repeat (8) tick();
    chk("at09_r", if24.rightHr, 9);
    @(negedge clk) set_btn = 1'b1;
    cyc(3);
    hr_tick = 1'b1;
    @(negedge clk) hr_tick = 1'b0;
    chk("coinc_l", if24.leftHr, 1);
    chk("coinc_r", if24.rightHr, 0);
    chk("coinc_set", if24.setting, 1);
    set_btn = 1'b0;
    cyc(2);

    // async reset mid-adjust at 17
    repeat (7) press(1);
    chk("at17_l", if24.leftHr, 1);
    chk("at17_r", if24.rightHr, 7);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_l", if24.leftHr, 0);
    chk("arst_r", if24.rightHr, 0);
    chk("arst_set", if24.setting, 0);
    chk("arst12_r", if12.rightHr, 2);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("post_rst_r", if24.rightHr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hours_counter.md
# hours_counter

Producer side of the hour display path: keeps the current hour as two BCD digits (tens 0–2 on 2 bits, units 0–9 on 4 bits), which the hour display controller registers and drives to the digits. It advances on a one-cycle carry from the minutes counter and supports manual setting through synchronised push-buttons. 24-hour or 12-hour (with PM flag) counting is chosen at elaboration.

## Interface
- `MODE_24`, default 1: 1 = 00..23 counting; 0 = 12,1..11 counting with `pm` flag.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `hr_tick`  in  1  one-cycle carry pulse from minutes counter (59→00), synchronous to `clk`.
- `set_btn`  in  1  raw button, asynchronous; each press toggles RUN/SET.
- `inc_btn`  in  1  raw button, asynchronous; +1 hour per press in SET.
- `dec_btn`  in  1  raw button, asynchronous; −1 hour per press in SET.
- `leftHr`  out  2  tens digit, BCD.
- `rightHr`  out  4  units digit, BCD, always 0–9.
- `pm`  out  1  PM flag; constant 0 when `MODE_24`=1.
- `setting`  out  1  high while in SET (drives display blink).
- `day_tick`  out  1  one-cycle pulse on midnight rollover in RUN.

## Operation
- State machine, two states: RUN (reset state), SET.
  - RUN→SET and SET→RUN on each synchronised rising edge of `set_btn`.
- RUN: `hr_tick`=1 increments the hour. `inc_btn`/`dec_btn` edges are ignored.
- SET: `hr_tick` is ignored and discarded (not queued). An `inc_btn` edge increments the hour; a `dec_btn` edge decrements it.
  - `inc_btn` and `dec_btn` edges in the same cycle: no change.
- 24h increment: 09→10, 19→20, 23→00. 24h decrement: 10→09, 20→19, 00→23.
- 12h increment: 12→01, 09→10, 11→12 with `pm` toggled. 12h decrement: 01→12, 10→09, 12→11 with `pm` toggled.
- `day_tick` pulses only for a RUN increment into midnight: 23→00 in 24h, or 11 PM→12 AM in 12h. It never pulses for a SET adjustment.
- `hr_tick` and a `set_btn` edge in the same RUN cycle: the increment is applied and the state moves to SET.
- Digits are held internally as BCD (no binary-to-BCD conversion). Illegal values are unreachable; any illegal value is forced to the reset value on the next clock.
- Reset values:
  - `MODE_24`=1: `leftHr`=0, `rightHr`=0, `pm`=0.
  - `MODE_24`=0: `leftHr`=1, `rightHr`=2, `pm`=0 (12 AM).
  - Both modes: `setting`=0, `day_tick`=0, state RUN, synchroniser and edge flops 0.
- Reset asserted mid-adjustment returns to the reset values immediately, regardless of `clk`.

## Timing
- All outputs are registered; no combinational input→output path.
- `hr_tick` in cycle N: new digits, `pm` and `day_tick` are visible after edge N+1 (1-cycle latency).
- Button path: 2-flop synchroniser, then a registered rising-edge detect. Press visible at the FSM about 3 cycles after the raw edge; hour updated one cycle later.
- Each button press yields exactly one step, however long it is held. No auto-repeat. Debounce is handled upstream.
- `day_tick` is high for exactly one cycle.

## Structure
- Package `hours_pkg`:
  - state enum `hr_state_t` {RUN, SET};
  - constants `HR24_MAX_L`=2, `HR24_MAX_R`=3, `HR12_MAX_L`=1, `HR12_MAX_R`=2, `BCD_MAX`=9.
- Sub-module `btn_sync_edge`: synchroniser plus one-cycle rising-edge pulse. Same `clk`/`rst`; instantiated three times.
- Top holds the FSM and the BCD step logic. Step logic is one increment path and one decrement path, each selected by `MODE_24`.

## Test plan
- Reset with `MODE_24`=1, then 24 `hr_tick` pulses: sequence 00,01…23,00; `day_tick` pulses once, on the 23→00 update only.
- `MODE_24`=0, from reset (12 AM), 12 ticks: 01…11, then 12 with `pm`=1; 12 more ticks return to 12 AM with a single `day_tick`.
- Press `set_btn` (`setting`=1), then `dec_btn` once from 00: 23. Apply `hr_tick` pulses: no change. Press `set_btn`: `setting`=0. The next tick gives 00 with `day_tick`=1.
- In SET, hold `inc_btn` high for 50 cycles: exactly +1. `inc_btn` and `dec_btn` rising in the same cycle: no change.
- In RUN at 09, `hr_tick` and a synchronised `set_btn` edge in the same cycle: hour becomes 10 and `setting`=1.
- Assert `rst` asynchronously between clock edges during SET at 17: outputs become 00, `setting`=0 before the next edge.
